// File: rtl/tinyalu_arbiter_if.sv
// rtl/tinyalu_arbiter_if.sv - requester bus and TinyALU handshake bundle for tinyalu_arbiter
interface tinyalu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Requester side
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_A;
    logic [8*NUM_REQ-1:0] req_B;
    logic [3*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   req_grant;
    logic                 rsp_valid;
    logic [2:0]           rsp_id;
    logic [15:0]          rsp_result;
    logic                 rsp_error;

    // TinyALU side
    logic [7:0]           alu_A;
    logic [7:0]           alu_B;
    logic [2:0]           alu_op;
    logic                 alu_start;
    logic                 alu_done;
    logic [15:0]          alu_result;

    // The arbiter itself
    modport slave (
        input  req_valid, req_A, req_B, req_op,
        output req_grant, rsp_valid, rsp_id, rsp_result, rsp_error,
        output alu_A, alu_B, alu_op, alu_start,
        input  alu_done, alu_result
    );

    // The requesters plus the TinyALU instance, seen as one environment
    modport master (
        output req_valid, req_A, req_B, req_op,
        input  req_grant, rsp_valid, rsp_id, rsp_result, rsp_error,
        input  alu_A, alu_B, alu_op, alu_start,
        output alu_done, alu_result
    );
endinterface

// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin scheduler sharing one TinyALU; optional counters via TINYALU_ARB_STATS_EN
module tinyalu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    tinyalu_arbiter_if.slave  bus
`ifdef TINYALU_ARB_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_errs
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAST_INIT = 3'(NUM_REQ - 1);
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] NUM_REQ4  = 4'(NUM_REQ);

    // Registered state and outputs
    state_t             r_state;
    logic [2:0]         r_last;
    logic [7:0]         r_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]         r_alu_A;
    logic [7:0]         r_alu_B;
    logic [2:0]         r_alu_op;
    logic               r_alu_start;
    logic [2:0]         r_id;
    logic [15:0]        r_res;
    logic               r_err;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_result;
    logic               r_rsp_error;

    // Next-state values
    state_t             w_state_nxt;
    logic [2:0]         w_last_nxt;
    logic [7:0]         w_cnt_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [7:0]         w_alu_A_nxt;
    logic [7:0]         w_alu_B_nxt;
    logic [2:0]         w_alu_op_nxt;
    logic               w_alu_start_nxt;
    logic [2:0]         w_id_nxt;
    logic [15:0]        w_res_nxt;
    logic               w_err_nxt;
    logic               w_rsp_valid_nxt;
    logic [15:0]        w_rsp_result_nxt;
    logic               w_rsp_error_nxt;

    // Requester buses widened to the 8-requester maximum so a 3-bit index
    // always selects exactly one lane.
    logic [7:0]         w_valid8;
    logic [63:0]        w_reqA64;
    logic [63:0]        w_reqB64;
    logic [23:0]        w_op24;

    logic               w_found;
    logic [2:0]         w_win;
    logic [3:0]         w_cand4;
    logic [4:0]         w_op_base;
    logic [7:0]         w_win_A;
    logic [7:0]         w_win_B;
    logic [2:0]         w_win_op;
    logic               w_win_alu;

    assign w_valid8 = 8'(bus.req_valid);
    assign w_reqA64 = 64'(bus.req_A);
    assign w_reqB64 = 64'(bus.req_B);
    assign w_op24   = 24'(bus.req_op);

    // Round-robin search: first valid requester starting just after the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand4 = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand4 = {1'b0, r_last} + 4'(k);
            if (w_cand4 >= NUM_REQ4) begin
                w_cand4 = w_cand4 - NUM_REQ4;
            end
            if (!w_found && w_valid8[w_cand4[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand4[2:0];
            end
        end
    end

    // Operand and op code of the current round-robin winner
    always_comb begin
        w_op_base = 5'(w_win) * 5'd3;
        w_win_A   = w_reqA64[{w_win, 3'b000} +: 8];
        w_win_B   = w_reqB64[{w_win, 3'b000} +: 8];
        w_win_op  = w_op24[w_op_base +: 3];
        // Only add, and, xor and mul are sent to the ALU
        w_win_alu = (w_win_op >= 3'b001) && (w_win_op <= 3'b100);
    end

    // Next-state and registered-output logic of the scheduler FSM
    always_comb begin
        w_state_nxt      = r_state;
        w_last_nxt       = r_last;
        w_cnt_nxt        = r_cnt;
        w_grant_nxt      = '0;
        w_alu_A_nxt      = r_alu_A;
        w_alu_B_nxt      = r_alu_B;
        w_alu_op_nxt     = r_alu_op;
        w_alu_start_nxt  = r_alu_start;
        w_id_nxt         = r_id;
        w_res_nxt        = r_res;
        w_err_nxt        = r_err;
        w_rsp_valid_nxt  = 1'b0;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_error_nxt  = r_rsp_error;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        w_grant_nxt[i] = (3'(i) == w_win);
                    end
                    w_last_nxt   = w_win;
                    w_id_nxt     = w_win;
                    w_alu_A_nxt  = w_win_A;
                    w_alu_B_nxt  = w_win_B;
                    w_alu_op_nxt = w_win_op;
                    w_cnt_nxt    = 8'd0;
                    if (w_win_alu) begin
                        w_alu_start_nxt = 1'b1;
                        w_state_nxt     = EXEC;
                    end else begin
                        // no_op and illegal codes are answered without the ALU
                        w_res_nxt   = 16'h0000;
                        w_err_nxt   = (w_win_op != 3'b000);
                        w_state_nxt = RESP;
                    end
                end
            end

            EXEC: begin
                if (bus.alu_done) begin
                    // A done on the last allowed cycle still counts as success
                    w_alu_start_nxt  = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = bus.alu_result;
                    w_rsp_error_nxt  = 1'b0;
                    w_state_nxt      = RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_alu_start_nxt  = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = 16'h0000;
                    w_rsp_error_nxt  = 1'b1;
                    w_state_nxt      = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            RESP: begin
                // ALU results arrive with the pulse already raised; local
                // answers spend their first RESP cycle raising it.
                if (r_rsp_valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = r_res;
                    w_rsp_error_nxt  = r_err;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_alu_start_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything, including a live ALU start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last       <= LAST_INIT;
            r_cnt        <= 8'd0;
            r_grant      <= '0;
            r_alu_A      <= 8'd0;
            r_alu_B      <= 8'd0;
            r_alu_op     <= 3'd0;
            r_alu_start  <= 1'b0;
            r_id         <= 3'd0;
            r_res        <= 16'h0000;
            r_err        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 16'h0000;
            r_rsp_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_alu_A      <= w_alu_A_nxt;
            r_alu_B      <= w_alu_B_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_alu_start  <= w_alu_start_nxt;
            r_id         <= w_id_nxt;
            r_res        <= w_res_nxt;
            r_err        <= w_err_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_error  <= w_rsp_error_nxt;
        end
    end

    assign bus.req_grant  = r_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_error  = r_rsp_error;
    assign bus.alu_A      = r_alu_A;
    assign bus.alu_B      = r_alu_B;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_start  = r_alu_start;

`ifdef TINYALU_ARB_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_errs;

    // Saturating response and error counters, advanced once per response pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_ops  <= 16'h0000;
            r_stat_errs <= 16'h0000;
        end else if (r_rsp_valid) begin
            if (r_stat_ops != 16'hFFFF) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if (r_rsp_error && (r_stat_errs != 16'hFFFF)) begin
                r_stat_errs <= r_stat_errs + 16'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`endif

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb/tb_tinyalu_arbiter.sv - directed-vector bench for tinyalu_arbiter with a TinyALU timing model
module tb_tinyalu_arbiter;

    logic clk;
    logic reset_n;

    tinyalu_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef TINYALU_ARB_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    tinyalu_arbiter #(.NUM_REQ(4), .TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef TINYALU_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    logic alu_hang = 1'b0;
    int   alu_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TinyALU timing model: one cycle for add/and/xor, three for mul, or never when hung
    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.alu_done   <= 1'b0;
            bus.alu_result <= 16'h0000;
            alu_cnt        <= 0;
        end else if (!bus.alu_start || bus.alu_done) begin
            bus.alu_done <= 1'b0;
            alu_cnt      <= 0;
        end else if (!alu_hang) begin
            if (alu_cnt == ((bus.alu_op == 3'b100) ? 2 : 0)) begin
                bus.alu_done   <= 1'b1;
                bus.alu_result <= alu_calc(bus.alu_A, bus.alu_B, bus.alu_op);
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Present one request, drop it on grant, then wait for its response
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         output logic [3:0] gnt, output int lat, output int st_cyc,
                         output logic [15:0] res, output logic err, output logic [2:0] id);
        int n;
        @(negedge clk);
        bus.req_A[8*i +: 8]  = a;
        bus.req_B[8*i +: 8]  = b;
        bus.req_op[3*i +: 3] = op;
        bus.req_valid[i]     = 1'b1;
        gnt = '0; lat = -1; st_cyc = 0; res = '0; err = 1'b0; id = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_grant == 4'b0000 && n < 40);
        gnt = bus.req_grant;
        bus.req_valid[i] = 1'b0;
        if (gnt != 4'b0000) begin
            n = 0;
            while (!bus.rsp_valid && n < 40) begin
                if (bus.alu_start) st_cyc++;
                @(negedge clk);
                n++;
            end
            if (bus.rsp_valid) begin
                lat = n;
                res = bus.rsp_result;
                err = bus.rsp_error;
                id  = bus.rsp_id;
            end
        end
    endtask

    // Wait up to a bound for any grant and return it (zero on expiry)
    task automatic wait_grant(output logic [3:0] gnt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_grant == 4'b0000 && n < 40);
        gnt = bus.req_grant;
    endtask

    logic [3:0]  gnt;
    int          lat;
    int          st_cyc;
    logic [15:0] res;
    logic        err;
    logic [2:0]  id;

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_A     = '0;
        bus.req_B     = '0;
        bus.req_op    = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(bus.req_grant), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_alu_start", 32'(bus.alu_start), 32'h0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
        reset_n = 1'b1;

        // Single add from requester 2
        issue(2, 8'h0F, 8'h01, 3'b001, gnt, lat, st_cyc, res, err, id);
        chk("add_grant", 32'(gnt), 32'h4);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_id", 32'(id), 32'd2);
        chk("add_result", 32'(res), 32'h0010);
        chk("add_error", 32'(err), 32'h0);

        // Mul with a three-cycle ALU
        issue(0, 8'hFF, 8'hFF, 3'b100, gnt, lat, st_cyc, res, err, id);
        chk("mul_grant", 32'(gnt), 32'h1);
        chk("mul_latency", 32'(lat), 32'd4);
        chk("mul_result", 32'(res), 32'hFE01);
        chk("mul_error", 32'(err), 32'h0);
        chk("mul_start_low_at_rsp", 32'(bus.alu_start), 32'h0);

        // and / xor
        issue(3, 8'hF0, 8'h3C, 3'b010, gnt, lat, st_cyc, res, err, id);
        chk("and_result", 32'(res), 32'h0030);
        chk("and_id", 32'(id), 32'd3);
        issue(1, 8'hF0, 8'h3C, 3'b011, gnt, lat, st_cyc, res, err, id);
        chk("xor_result", 32'(res), 32'h00CC);
        chk("xor_latency", 32'(lat), 32'd2);

        // Local answers: no_op and an illegal code
        issue(1, 8'h12, 8'h34, 3'b000, gnt, lat, st_cyc, res, err, id);
        chk("noop_latency", 32'(lat), 32'd1);
        chk("noop_result", 32'(res), 32'h0);
        chk("noop_error", 32'(err), 32'h0);
        chk("noop_start_cycles", 32'(st_cyc), 32'd0);
        issue(3, 8'h12, 8'h34, 3'b110, gnt, lat, st_cyc, res, err, id);
        chk("ill_latency", 32'(lat), 32'd1);
        chk("ill_error", 32'(err), 32'h1);
        chk("ill_result", 32'(res), 32'h0);
        chk("ill_start_cycles", 32'(st_cyc), 32'd0);
        chk("ill_id", 32'(id), 32'd3);

        // Timeout: the ALU never answers an add
        alu_hang = 1'b1;
        issue(0, 8'h01, 8'h02, 3'b001, gnt, lat, st_cyc, res, err, id);
        alu_hang = 1'b0;
        chk("tmo_start_cycles", 32'(st_cyc), 32'd15);
        chk("tmo_latency", 32'(lat), 32'd15);
        chk("tmo_error", 32'(err), 32'h1);
        chk("tmo_result", 32'(res), 32'h0);
        issue(2, 8'h05, 8'h06, 3'b001, gnt, lat, st_cyc, res, err, id);
        chk("post_tmo_result", 32'(res), 32'h000B);

        // After reset last=3: valid 4'b1001 grants 0 first, then 3
        do_reset();
        bus.req_op = '0;
        bus.req_valid = 4'b1001;
        wait_grant(gnt);
        chk("wrap_first", 32'(gnt), 32'h1);
        bus.req_valid[0] = 1'b0;
        wait_grant(gnt);
        chk("wrap_second", 32'(gnt), 32'h8);
        bus.req_valid = '0;

        // Fairness with all four requesters continuously re-requesting
        do_reset();
        bus.req_A  = 32'h04030201;
        bus.req_B  = 32'h10101010;
        bus.req_op = {3'b001, 3'b001, 3'b001, 3'b001};
        bus.req_valid = 4'b1111;
        begin
            int k;
            int n;
            int exp_seq[5] = '{0, 1, 2, 3, 0};
            k = 0;
            n = 0;
            while (k < 5 && n < 300) begin
                @(negedge clk);
                n++;
                if (bus.rsp_valid) bus.req_valid[bus.rsp_id[1:0]] = 1'b1;
                if (bus.req_grant != 4'b0000) begin
                    for (int j = 0; j < 4; j++) begin
                        if (bus.req_grant[j]) begin
                            chk($sformatf("rr_%0d", k), 32'(j), 32'(exp_seq[k]));
                            bus.req_valid[j] = 1'b0;
                        end
                    end
                    k++;
                end
            end
            chk("rr_count", 32'(k), 32'd5);
        end
        bus.req_valid = '0;
        repeat (6) @(negedge clk);

        // Reset in the middle of a mul
        bus.req_A[23:16] = 8'h77;
        bus.req_B[23:16] = 8'h02;
        bus.req_op[8:6]  = 3'b100;
        bus.req_valid[2] = 1'b1;
        wait_grant(gnt);
        chk("mid_grant", 32'(gnt), 32'h4);
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        chk("mid_start_before", 32'(bus.alu_start), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_start_async", 32'(bus.alu_start), 32'h0);
        chk("mid_alu_A", 32'(bus.alu_A), 32'h0);
        chk("mid_alu_op", 32'(bus.alu_op), 32'h0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (bus.rsp_valid) seen = 1'b1;
            end
            reset_n = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (bus.rsp_valid) seen = 1'b1;
            end
            chk("mid_no_rsp", 32'(seen), 32'h0);
        end
        bus.req_op = '0;
        bus.req_valid = 4'b0101;
        wait_grant(gnt);
        chk("mid_next_grant", 32'(gnt), 32'h1);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tinyalu_arbiter.md
Name: tinyalu_arbiter

Overview:
- Round-robin scheduler that shares one TinyALU between NUM_REQ requesters.
- Arbitrates requests, latches the winner's operands and drives the ALU start/op handshake until done.
- Routes the 16-bit result back to the winner with its requester ID.
- Answers no_op and illegal op codes locally, and aborts hung operations with a timeout; sits between the requester bus and the TinyALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 15, max cycles in EXEC waiting for alu_done before abort (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request; held with operands until granted
req_A  input  8*NUM_REQ  operand A, requester i at bits [8i+7:8i]
req_B  input  8*NUM_REQ  operand B, same packing
req_op  input  3*NUM_REQ  op code, requester i at [3i+2:3i]; 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal
req_grant  output  NUM_REQ  one-hot one-cycle acceptance pulse
rsp_valid  output  1  one-cycle response pulse
rsp_id  output  3  requester index of the response
rsp_result  output  16  result (0 on no_op/error)
rsp_error  output  1  high with rsp_valid on illegal op or timeout
alu_A  output  8  to TinyALU A
alu_B  output  8  to TinyALU B
alu_op  output  3  to TinyALU op
alu_start  output  1  to TinyALU start
alu_done  input  1  from TinyALU done
alu_result  input  16  from TinyALU result

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; round-robin pointer last=NUM_REQ-1; timeout counter 0.
- Reset mid-operation aborts immediately; no response is issued; alu_start drops asynchronously.
- FSM states: IDLE, EXEC, RESP. All outputs are registered.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid: pick the first valid index searching from last+1 with wrap (last=3, valid=4'b1001 -> grant 0). At the next edge:
  - req_grant[i]=1 for exactly one cycle; last=i.
  - alu_A/alu_B/alu_op and an internal id register take requester i's values.
- IDLE, winner op is 001..100: alu_start=1 at that same edge; go to EXEC.
- IDLE, winner op is 000 or 101..111: ALU untouched; go to RESP with result 0; error=1 for illegal codes, error=0 for no_op.
- EXEC:
  - alu_start and operands held stable; counter increments each cycle.
  - On an edge sampling alu_done=1: alu_start<=0, capture alu_result, go to RESP.
  - Counter reaching TIMEOUT without done: alu_start<=0, result 0, error=1, go to RESP.
- RESP: rsp_valid=1 for one cycle with rsp_id, rsp_result, rsp_error; next state IDLE. The next grant comes no earlier than one cycle after RESP.
- Latency, grant-to-response: add/and/xor = grant edge + 1 ALU cycle + RESP, giving rsp_valid 2 cycles after req_grant. Mul is 2 cycles later than add/and/xor (3-cycle ALU). no_op/illegal: rsp_valid 1 cycle after grant.
- Requester rules:
  - Deassert req_valid the cycle after req_grant, or it is re-arbitrated.
  - Operands may change after grant without effect.
  - A requester whose req_valid is already high may see a response and a new grant in separate cycles; there is no pipelining and at most one operation is outstanding.
- Fairness: with all NUM_REQ valid continuously, grants rotate 0,1,2,3,0,...
- rsp_id is 3 bits regardless of NUM_REQ; unused upper bits are 0.

Optional Feature:
- Macro: TINYALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ops (16-bit) and stat_errs (16-bit).
  - stat_ops increments on every rsp_valid; stat_errs increments on rsp_valid with rsp_error.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single add: requester 2 sends A=8'h0F, B=8'h01, op=001, ALU done one cycle after start -> req_grant=4'b0100; rsp_valid 2 cycles later with rsp_id=2, rsp_result=16'h0010, rsp_error=0.
- Mul: A=8'hFF, B=8'hFF, op=100 with a 3-cycle ALU model -> alu_start high 3 cycles, rsp_result=16'hFE01, rsp_valid 4 cycles after grant.
- Round-robin: all 4 requesters valid, each re-asserting after its response -> grant order 0,1,2,3,0; no requester granted twice before the others.
- Local ops: op=000 -> rsp_result=0, rsp_error=0, alu_start never asserted. op=110 -> rsp_error=1, alu_start never asserted.
- Timeout: ALU model never raises done on add -> alu_start drops after TIMEOUT=15 cycles in EXEC; rsp_error=1, rsp_result=0, FSM returns to IDLE.
- Reset mid-EXEC: assert reset_n=0 during mul -> all outputs 0 immediately, no rsp_valid; after release, next request granted from index 0.
